mm_job_scheduler: RTL

Sequences matrix-multiply jobs from two independent requesters onto the single 2x2 compute engine. Arbitrates requesters round-robin and drives the engine's cfg_k/start/done handshake. Monitors the engine's C output stream for beat-count and tlast correctness, then returns a per-job completion response with requester id, tag and error code. Sits between the host/DMA command logic and the compute engine's control pins; A/B/C data streams do not pass through it.

---
 rtl/mm_sched_pkg.sv | 34 +++
 rtl/mm_rr_arb2.sv | 50 +++++
 rtl/mm_job_scheduler.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/mm_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mm_sched_pkg
// Purpose  : Shared types and constants for the matrix-multiply job scheduler
//            (FSM state encoding, response error codes, C-stream beat count).
// Revision : 1.0 - initial release
// ============================================================================
package mm_sched_pkg;

  // Scheduler FSM states
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_WAIT_DONE = 3'd2,
    ST_RELEASE   = 3'd3,
    ST_RESP      = 3'd4
  } state_t;

  // Completion response error codes (value is what appears on rsp_err)
  typedef enum logic [1:0] {
    ERR_OK      = 2'd0,
    ERR_BAD_K   = 2'd1,
    ERR_BEAT    = 2'd2,
    ERR_TIMEOUT = 2'd3
  } err_t;

  // A 2x2 result tile always leaves the engine as exactly this many C beats
  localparam int NUM_C_BEATS = 4;

  // Beat counter width; the counter saturates at its all-ones value (7)
  localparam int BEAT_CNT_W = 3;

endpackage
`default_nettype wire

// File: rtl/mm_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module   : mm_rr_arb2
// Purpose  : Two-requester round-robin arbiter. Produces a one-hot grant; on
//            an update strobe the priority pointer moves to the requester that
//            did not win, so a continuously-requesting pair alternates.
// Revision : 1.0 - initial release
// ============================================================================
module mm_rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] grant
);

  // ptr_q names the requester that wins when both request (0 after reset)
  logic ptr_q;
  logic ptr_d;

  // Grant: a lone requester wins outright, a tie goes to the pointer
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = ptr_q ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

  // Pointer update: after granting requester 0 point at 1, and vice versa
  always_comb begin
    ptr_d = ptr_q;
    if (update && (grant != 2'b00)) begin
      ptr_d = grant[0];
    end
  end

  // Pointer register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mm_job_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : mm_job_scheduler
// Purpose  : Accepts matrix-multiply jobs from two requesters (round-robin),
//            drives the 2x2 engine cfg_k/start/done handshake, checks the C
//            output stream for beat count and tlast placement, and returns a
//            per-job completion response (id, tag, error code).
// Options  : MM_SCHED_WATCHDOG_EN - adds a WAIT_DONE/RELEASE cycle watchdog
//            with a sticky wdog_fault that blocks further grants.
// Revision : 1.0 - initial release
// ============================================================================
module mm_job_scheduler
  import mm_sched_pkg::*;
#(
  parameter int K_MAX = 2,
  parameter int K_W   = $clog2(K_MAX) + 1,
  parameter int TAG_W = 4
`ifdef MM_SCHED_WATCHDOG_EN
  ,
  parameter int TIMEOUT_CYC = 1024
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [K_W-1:0]   req0_k,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [K_W-1:0]   req1_k,
  input  logic [TAG_W-1:0] req1_tag,
  output logic [K_W-1:0]   engine_cfg_k,
  output logic             engine_start,
  input  logic             engine_done,
  input  logic             mon_c_tvalid,
  input  logic             mon_c_tready,
  input  logic             mon_c_tlast,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [TAG_W-1:0] rsp_tag,
  output logic [1:0]       rsp_err,
  output logic             busy,
  output logic             wdog_fault
);

  localparam logic [BEAT_CNT_W-1:0] BEAT_CNT_MAX = '1;
  localparam logic [BEAT_CNT_W-1:0] BEAT_CNT_LAST = BEAT_CNT_W'(NUM_C_BEATS);

  state_t                state_q, state_d;
  logic [K_W-1:0]        k_q, k_d;
  logic [TAG_W-1:0]      tag_q, tag_d;
  logic                  id_q, id_d;
  err_t                  err_q, err_d;
  logic [BEAT_CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [BEAT_CNT_W-1:0] beat_cnt_inc;
  logic                  beat_err_q, beat_err_d;

  logic [1:0]            arb_req;
  logic [1:0]            arb_grant;
  logic                  handshake;
  logic [K_W-1:0]        req_k;
  logic [TAG_W-1:0]      req_tag;
  logic                  beat_fire;
  logic                  grant_block;
  logic                  wd_trip;

  // Only offer requests to the arbiter while idle and not faulted
  assign arb_req   = {req1_valid, req0_valid} & {2{(state_q == ST_IDLE) && !grant_block}};
  assign handshake = |arb_grant;
  assign req0_ready = arb_grant[0];
  assign req1_ready = arb_grant[1];
  assign req_k     = arb_grant[1] ? req1_k   : req0_k;
  assign req_tag   = arb_grant[1] ? req1_tag : req0_tag;
  assign beat_fire = mon_c_tvalid & mon_c_tready;

  mm_rr_arb2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (arb_req),
    .update (handshake),
    .grant  (arb_grant)
  );

`ifdef MM_SCHED_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC) + 1;

  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
  logic            wdog_fault_q, wdog_fault_d;
  logic            wd_expire;

  // Expire on the cycle whose increment would bring the count to TIMEOUT_CYC
  assign wd_expire   = (wd_cnt_q == WD_W'(TIMEOUT_CYC - 1));
  // Trip only when the engine has not already produced a normal exit
  assign wd_trip     = wd_expire &&
                       (((state_q == ST_WAIT_DONE) && !engine_done) ||
                        ((state_q == ST_RELEASE)   &&  engine_done));
  assign grant_block = wdog_fault_q;
  assign wdog_fault  = wdog_fault_q;

  // Watchdog counter and sticky fault next-state
  always_comb begin
    wd_cnt_d     = wd_cnt_q;
    wdog_fault_d = wdog_fault_q;
    if (state_q == ST_START) begin
      wd_cnt_d = '0;
    end else if ((state_q == ST_WAIT_DONE) || (state_q == ST_RELEASE)) begin
      wd_cnt_d = wd_cnt_q + 1'b1;
    end
    if (wd_trip) begin
      wdog_fault_d = 1'b1;
    end
  end

  // Watchdog registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt_q     <= '0;
      wdog_fault_q <= 1'b0;
    end else begin
      wd_cnt_q     <= wd_cnt_d;
      wdog_fault_q <= wdog_fault_d;
    end
  end
`else
  assign wd_trip     = 1'b0;
  assign grant_block = 1'b0;
  assign wdog_fault  = 1'b0;
`endif

  // FSM next-state, job latching, and C-stream beat checking
  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    tag_d        = tag_q;
    id_d         = id_q;
    err_d        = err_q;
    beat_cnt_d   = beat_cnt_q;
    beat_err_d   = beat_err_q;
    beat_cnt_inc = (beat_cnt_q == BEAT_CNT_MAX) ? beat_cnt_q : (beat_cnt_q + 1'b1);

    case (state_q)
      ST_IDLE: begin
        if (handshake) begin
          k_d   = req_k;
          tag_d = req_tag;
          id_d  = arb_grant[1];
          if ((req_k == '0) || (req_k > K_W'(K_MAX))) begin
            err_d   = ERR_BAD_K;
            state_d = ST_RESP;
          end else begin
            err_d   = ERR_OK;
            state_d = ST_START;
          end
        end
      end

      ST_START: begin
        beat_cnt_d = '0;
        beat_err_d = 1'b0;
        state_d    = ST_WAIT_DONE;
      end

      ST_WAIT_DONE: begin
        // tlast must coincide exactly with the final beat
        if (beat_fire) begin
          beat_cnt_d = beat_cnt_inc;
          if (mon_c_tlast != (beat_cnt_inc == BEAT_CNT_LAST)) begin
            beat_err_d = 1'b1;
          end
        end
        // A beat arriving with done is already folded into the _d values
        if (engine_done) begin
          err_d   = (beat_err_d || (beat_cnt_d != BEAT_CNT_LAST)) ? ERR_BEAT : ERR_OK;
          state_d = ST_RELEASE;
        end else if (wd_trip) begin
          err_d   = ERR_TIMEOUT;
          state_d = ST_RESP;
        end
      end

      ST_RELEASE: begin
        if (!engine_done) begin
          state_d = ST_RESP;
        end else if (wd_trip) begin
          err_d   = ERR_TIMEOUT;
          state_d = ST_RESP;
        end
      end

      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Scheduler state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      k_q        <= '0;
      tag_q      <= '0;
      id_q       <= 1'b0;
      err_q      <= ERR_OK;
      beat_cnt_q <= '0;
      beat_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      tag_q      <= tag_d;
      id_q       <= id_d;
      err_q      <= err_d;
      beat_cnt_q <= beat_cnt_d;
      beat_err_q <= beat_err_d;
    end
  end

  // Engine pins are decoded from state so an async reset drops start at once;
  // a BAD_K job never reaches these states, so the engine never sees its k
  assign engine_start = (state_q == ST_START) || (state_q == ST_WAIT_DONE);
  assign engine_cfg_k = ((state_q == ST_START) || (state_q == ST_WAIT_DONE) ||
                         (state_q == ST_RELEASE)) ? k_q : '0;

  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_id    = id_q;
  assign rsp_tag   = tag_q;
  assign rsp_err   = err_q;
  assign busy      = (state_q != ST_IDLE);

endmodule
`default_nettype wire
